dca_matrix_lsu_txn_gen: RTL and testbench

- Transaction scheduler for the DCA matrix LSU store/load datapath.
- Accepts one matrix LSU instruction (base address, row stride, row/column counts, opcode).
- Breaks it into per-row AXI burst transactions and presents them one at a time on a valid/ready transaction-info port.
- Sits between the LSU instruction decoder and the store/load request path; the store path consumes bitaddr/alen/last per transaction.

---
 rtl/dca_matrix_lsu_txn_gen.sv | 189 ++++++++++++++++++
 tb/tb_dca_matrix_lsu_txn_gen.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/dca_matrix_lsu_txn_gen.sv
// Matrix LSU transaction generator.
// Takes one matrix load/store instruction and splits it into per-row AXI
// bursts of at most MAX_BURST_LEN beats. Each burst is offered on a
// valid/ready port as bit address, ALEN, opcode and last flag.
module dca_matrix_lsu_txn_gen #(
  parameter int BW_ADDR       = 32,
  parameter int BW_AXI_DATA   = 32,
  parameter int BW_ELEMENT    = 32,
  parameter int BW_DIM        = 8,
  parameter int MAX_BURST_LEN = 16
) (
  input  logic               clk,
  input  logic               rstnn,
  input  logic               clear,
  input  logic               inst_valid,
  output logic               inst_ready,
  input  logic               inst_is_write,
  input  logic [BW_ADDR-1:0] inst_addr,
  input  logic [BW_ADDR-1:0] inst_stride,
  input  logic [BW_DIM-1:0]  inst_num_row_m1,
  input  logic [BW_DIM-1:0]  inst_num_col_m1,
  output logic               txn_valid,
  input  logic               txn_ready,
  output logic [BW_ADDR+2:0] txn_bitaddr,
  output logic [7:0]         txn_alen,
  output logic               txn_is_write,
  output logic               txn_last,
  output logic               busy,
  output logic               done
);

  localparam int BYTES_PER_BEAT = BW_AXI_DATA / 8;
  localparam int OFF_BITS       = (BYTES_PER_BEAT > 1) ? $clog2(BYTES_PER_BEAT) : 0;
  // Wide enough for a full row of beats (up to 2^BW_DIM) and for MAX_BURST_LEN (up to 256).
  localparam int BW_BEATS       = (BW_DIM + 1 > 9) ? BW_DIM + 1 : 9;
  localparam logic [BW_BEATS-1:0] MAX_BEATS   = BW_BEATS'(MAX_BURST_LEN);
  localparam logic [BW_ADDR-1:0]  BURST_BYTES = BW_ADDR'(MAX_BURST_LEN * BYTES_PER_BEAT);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DONE} state_t;

  state_t              state_q, state_d;
  logic                is_write_q, is_write_d;
  logic [BW_DIM-1:0]   num_row_m1_q, num_row_m1_d;
  logic [BW_DIM-1:0]   row_idx_q, row_idx_d;
  logic [BW_ADDR-1:0]  stride_q, stride_d;
  logic [BW_ADDR-1:0]  row_base_q, row_base_d;
  logic [BW_ADDR-1:0]  cur_addr_q, cur_addr_d;
  logic [BW_BEATS-1:0] row_beats_q, row_beats_d;
  logic [BW_BEATS-1:0] beats_left_q, beats_left_d;

  logic                inst_ready_q, inst_ready_d;
  logic                txn_valid_q, txn_valid_d;
  logic [BW_ADDR+2:0]  txn_bitaddr_q, txn_bitaddr_d;
  logic [7:0]          txn_alen_q, txn_alen_d;
  logic                txn_last_q, txn_last_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic [BW_BEATS-1:0] row_beats_calc;
  logic [BW_BEATS-1:0] beats_now;
  logic [BW_ADDR-1:0]  aligned_addr;
  logic                issue_d;

  // Row length in beats and beat-aligned base address of the incoming instruction.
  always_comb begin
    row_beats_calc = BW_BEATS'(((32'(inst_num_col_m1) + 32'd1) * 32'(BW_ELEMENT)
                               + 32'(BW_AXI_DATA) - 32'd1) / 32'(BW_AXI_DATA));
    aligned_addr   = (inst_addr >> OFF_BITS) << OFF_BITS;
  end

  // Next-state, counter update and registered output computation.
  always_comb begin
    state_d      = state_q;
    is_write_d   = is_write_q;
    num_row_m1_d = num_row_m1_q;
    row_idx_d    = row_idx_q;
    stride_d     = stride_q;
    row_base_d   = row_base_q;
    cur_addr_d   = cur_addr_q;
    row_beats_d  = row_beats_q;
    beats_left_d = beats_left_q;

    case (state_q)
      S_IDLE: begin
        if (inst_valid && inst_ready_q) begin
          is_write_d   = inst_is_write;
          num_row_m1_d = inst_num_row_m1;
          stride_d     = inst_stride;
          row_base_d   = aligned_addr;
          cur_addr_d   = aligned_addr;
          row_beats_d  = row_beats_calc;
          beats_left_d = row_beats_calc;
          row_idx_d    = '0;
          state_d      = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (txn_valid_q && txn_ready) begin
          if (beats_left_q > MAX_BEATS) begin
            beats_left_d = beats_left_q - MAX_BEATS;
            cur_addr_d   = cur_addr_q + BURST_BYTES;
          end else if (txn_last_q) begin
            state_d = S_DONE;
          end else begin
            row_idx_d    = row_idx_q + 1'b1;
            row_base_d   = row_base_q + stride_q;
            cur_addr_d   = row_base_q + stride_q;
            beats_left_d = row_beats_q;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Abort: drop everything and return to IDLE without a done pulse.
    if (clear) begin
      state_d      = S_IDLE;
      is_write_d   = 1'b0;
      num_row_m1_d = '0;
      row_idx_d    = '0;
      stride_d     = '0;
      row_base_d   = '0;
      cur_addr_d   = '0;
      row_beats_d  = '0;
      beats_left_d = '0;
    end

    // Outputs are derived from next-state values so they appear registered.
    issue_d       = (state_d == S_ISSUE);
    beats_now     = (beats_left_d > MAX_BEATS) ? MAX_BEATS : beats_left_d;
    txn_valid_d   = issue_d;
    txn_alen_d    = issue_d ? 8'(beats_now - 1'b1) : 8'd0;
    txn_bitaddr_d = issue_d ? {cur_addr_d, 3'b000} : '0;
    txn_last_d    = issue_d && (row_idx_d == num_row_m1_d) && (beats_left_d <= MAX_BEATS);
    done_d        = (state_d == S_DONE);
    busy_d        = (state_d != S_IDLE);
    inst_ready_d  = (state_d == S_IDLE);
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      state_q       <= S_IDLE;
      is_write_q    <= 1'b0;
      num_row_m1_q  <= '0;
      row_idx_q     <= '0;
      stride_q      <= '0;
      row_base_q    <= '0;
      cur_addr_q    <= '0;
      row_beats_q   <= '0;
      beats_left_q  <= '0;
      inst_ready_q  <= 1'b1;
      txn_valid_q   <= 1'b0;
      txn_bitaddr_q <= '0;
      txn_alen_q    <= '0;
      txn_last_q    <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      is_write_q    <= is_write_d;
      num_row_m1_q  <= num_row_m1_d;
      row_idx_q     <= row_idx_d;
      stride_q      <= stride_d;
      row_base_q    <= row_base_d;
      cur_addr_q    <= cur_addr_d;
      row_beats_q   <= row_beats_d;
      beats_left_q  <= beats_left_d;
      inst_ready_q  <= inst_ready_d;
      txn_valid_q   <= txn_valid_d;
      txn_bitaddr_q <= txn_bitaddr_d;
      txn_alen_q    <= txn_alen_d;
      txn_last_q    <= txn_last_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  assign inst_ready   = inst_ready_q;
  assign txn_valid    = txn_valid_q;
  assign txn_bitaddr  = txn_bitaddr_q;
  assign txn_alen     = txn_alen_q;
  assign txn_is_write = is_write_q;
  assign txn_last     = txn_last_q;
  assign busy         = busy_q;
  assign done         = done_q;

endmodule

// File: tb/tb_dca_matrix_lsu_txn_gen.sv
// Directed bench for the matrix LSU transaction generator.
module tb_dca_matrix_lsu_txn_gen;

  logic        clk = 1'b0;
  logic        rstnn;
  logic        clear;
  logic        inst_valid;
  logic        inst_ready;
  logic        inst_is_write;
  logic [31:0] inst_addr;
  logic [31:0] inst_stride;
  logic [7:0]  inst_num_row_m1;
  logic [7:0]  inst_num_col_m1;
  logic        txn_valid;
  logic        txn_ready;
  logic [34:0] txn_bitaddr;
  logic [7:0]  txn_alen;
  logic        txn_is_write;
  logic        txn_last;
  logic        busy;
  logic        done;

  int checks   = 0;
  int failures = 0;

  dca_matrix_lsu_txn_gen dut (
    .clk             (clk),
    .rstnn           (rstnn),
    .clear           (clear),
    .inst_valid      (inst_valid),
    .inst_ready      (inst_ready),
    .inst_is_write   (inst_is_write),
    .inst_addr       (inst_addr),
    .inst_stride     (inst_stride),
    .inst_num_row_m1 (inst_num_row_m1),
    .inst_num_col_m1 (inst_num_col_m1),
    .txn_valid       (txn_valid),
    .txn_ready       (txn_ready),
    .txn_bitaddr     (txn_bitaddr),
    .txn_alen        (txn_alen),
    .txn_is_write    (txn_is_write),
    .txn_last        (txn_last),
    .busy            (busy),
    .done            (done)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; sample/drive 1ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_inst(input logic wr, input logic [31:0] addr, input logic [31:0] stride,
                            input logic [7:0] rm1, input logic [7:0] cm1);
    inst_is_write   = wr;
    inst_addr       = addr;
    inst_stride     = stride;
    inst_num_row_m1 = rm1;
    inst_num_col_m1 = cm1;
    inst_valid      = 1'b1;
    step();
    inst_valid      = 1'b0;
  endtask

  // Check the presented transaction, then advance one cycle.
  task automatic expect_txn(input string tag, input logic [34:0] ba, input logic [7:0] alen,
                            input logic last, input logic wr);
    check_val({tag, ".valid"}, 64'(txn_valid), 64'd1);
    check_val({tag, ".bitaddr"}, 64'(txn_bitaddr), 64'(ba));
    check_val({tag, ".alen"}, 64'(txn_alen), 64'(alen));
    check_val({tag, ".last"}, 64'(txn_last), 64'(last));
    check_val({tag, ".is_write"}, 64'(txn_is_write), 64'(wr));
    $display("txn %s bitaddr=0x%0h alen=%0d last=%0d wr=%0d ready=%0d",
             tag, txn_bitaddr, txn_alen, txn_last, txn_is_write, txn_ready);
    step();
  endtask

  task automatic expect_done(input string tag);
    check_val({tag, ".done"}, 64'(done), 64'd1);
    check_val({tag, ".done_valid"}, 64'(txn_valid), 64'd0);
    check_val({tag, ".done_ready"}, 64'(inst_ready), 64'd0);
    step();
    check_val({tag, ".idle_done"}, 64'(done), 64'd0);
    check_val({tag, ".idle_ready"}, 64'(inst_ready), 64'd1);
    check_val({tag, ".idle_busy"}, 64'(busy), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rstnn = 1'b0; clear = 1'b0; inst_valid = 1'b0; inst_is_write = 1'b0;
    inst_addr = '0; inst_stride = '0; inst_num_row_m1 = '0; inst_num_col_m1 = '0;
    txn_ready = 1'b1;
    #12;
    check_val("rst.valid", 64'(txn_valid), 64'd0);
    check_val("rst.done", 64'(done), 64'd0);
    check_val("rst.busy", 64'(busy), 64'd0);
    check_val("rst.inst_ready", 64'(inst_ready), 64'd1);
    check_val("rst.bitaddr", 64'(txn_bitaddr), 64'd0);
    check_val("rst.alen", 64'(txn_alen), 64'd0);
    check_val("rst.last", 64'(txn_last), 64'd0);
    check_val("rst.is_write", 64'(txn_is_write), 64'd0);
    @(negedge clk);
    rstnn = 1'b1;
    step();

    // 1x1 write
    issue_inst(1'b1, 32'h1000, 32'h0, 8'd0, 8'd0);
    check_val("t1.busy", 64'(busy), 64'd1);
    check_val("t1.inst_ready", 64'(inst_ready), 64'd0);
    expect_txn("t1.0", 35'h8000, 8'd0, 1'b1, 1'b1);
    expect_done("t1");

    // 3x4, stride 0x40, back-to-back
    issue_inst(1'b0, 32'h2000, 32'h40, 8'd2, 8'd3);
    expect_txn("t2.0", 35'h10000, 8'd3, 1'b0, 1'b0);
    expect_txn("t2.1", 35'h10200, 8'd3, 1'b0, 1'b0);
    expect_txn("t2.2", 35'h10400, 8'd3, 1'b1, 1'b0);
    expect_done("t2");

    // 1x20: split into 16 + 4 beats
    issue_inst(1'b1, 32'h3000, 32'h0, 8'd0, 8'd19);
    expect_txn("t3.0", 35'h18000, 8'd15, 1'b0, 1'b1);
    expect_txn("t3.1", 35'h18200, 8'd3, 1'b1, 1'b1);
    expect_done("t3");

    // Backpressure on second transaction of 3x4
    issue_inst(1'b1, 32'h2000, 32'h40, 8'd2, 8'd3);
    expect_txn("t4.0", 35'h10000, 8'd3, 1'b0, 1'b1);
    txn_ready = 1'b0;
    for (int i = 0; i < 5; i++) expect_txn("t4.hold", 35'h10200, 8'd3, 1'b0, 1'b1);
    txn_ready = 1'b1;
    expect_txn("t4.1", 35'h10200, 8'd3, 1'b0, 1'b1);
    expect_txn("t4.2", 35'h10400, 8'd3, 1'b1, 1'b1);
    expect_done("t4");

    // Unaligned 1x2 and a second instruction held during busy
    issue_inst(1'b1, 32'h1002, 32'h0, 8'd0, 8'd1);
    inst_is_write = 1'b0; inst_addr = 32'h4000; inst_num_row_m1 = 8'd0; inst_num_col_m1 = 8'd0;
    inst_valid = 1'b1;
    expect_txn("t5.0", 35'h8000, 8'd1, 1'b1, 1'b1);
    check_val("t5.done", 64'(done), 64'd1);
    check_val("t5.done_ready", 64'(inst_ready), 64'd0);
    step();
    check_val("t5.idle_ready", 64'(inst_ready), 64'd1);
    check_val("t5.idle_valid", 64'(txn_valid), 64'd0);
    step();
    inst_valid = 1'b0;
    expect_txn("t5.b", 35'h20000, 8'd0, 1'b1, 1'b0);
    expect_done("t5b");

    // clear during second transaction
    issue_inst(1'b0, 32'h2000, 32'h40, 8'd2, 8'd3);
    expect_txn("t6.0", 35'h10000, 8'd3, 1'b0, 1'b0);
    clear = 1'b1;
    step();
    clear = 1'b0;
    check_val("t6.valid", 64'(txn_valid), 64'd0);
    check_val("t6.busy", 64'(busy), 64'd0);
    check_val("t6.done", 64'(done), 64'd0);
    check_val("t6.inst_ready", 64'(inst_ready), 64'd1);
    step();
    check_val("t6.done2", 64'(done), 64'd0);

    // async reset during second transaction
    issue_inst(1'b1, 32'h2000, 32'h40, 8'd2, 8'd3);
    expect_txn("t7.0", 35'h10000, 8'd3, 1'b0, 1'b1);
    check_val("t7.pre_valid", 64'(txn_valid), 64'd1);
    #2;
    rstnn = 1'b0;
    #1;
    check_val("t7.valid", 64'(txn_valid), 64'd0);
    check_val("t7.busy", 64'(busy), 64'd0);
    check_val("t7.inst_ready", 64'(inst_ready), 64'd1);
    check_val("t7.bitaddr", 64'(txn_bitaddr), 64'd0);
    check_val("t7.alen", 64'(txn_alen), 64'd0);
    @(negedge clk);
    rstnn = 1'b1;
    step();
    check_val("t7.done", 64'(done), 64'd0);
    check_val("t7.valid2", 64'(txn_valid), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
